regfile_wb_queue: RTL and testbench



---
 rtl/regfile_wb_queue.sv | 116 +++++++++++
 tb/tb_regfile_wb_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back queue feeding active-low register file write ports
// Producers enqueue in index order; the oldest entries drain onto the lowest write ports.
module regfile_wb_queue #(
  parameter int DATA     = 32,
  parameter int ADDR     = 4,
  parameter int SRC      = 2,
  parameter int WRITE    = 1,
  parameter int CHK      = 2,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [SRC-1:0]             i_src_valid,
  output logic [SRC-1:0]             o_src_ready,
  input  logic [SRC-1:0][ADDR-1:0]   i_src_addr,
  input  logic [SRC-1:0][DATA-1:0]   i_src_data,
  output logic [WRITE-1:0][ADDR-1:0] o_waddr,
  output logic [WRITE-1:0]           o_we_,
  output logic [WRITE-1:0][DATA-1:0] o_wdata,
  input  logic [CHK-1:0][ADDR-1:0]   i_chk_addr,
  output logic [CHK-1:0]             o_chk_hit,
  output logic [CHK-1:0][DATA-1:0]   o_chk_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR-1:0] r_addr [DEPTH];
  logic [DATA-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [SRC-1:0]         w_enq;
  logic [SRC-1:0][PW-1:0] w_slot;
  logic [CW-1:0]          w_n_enq;
  logic [CW-1:0]          w_n_drain;
  logic [PW-1:0]          w_wptr;
  logic [PW-1:0]          w_fptr;
  logic                   w_active;

  // Ready comes only from the registered count so there is no src_valid -> src_ready path.
  always_comb begin
    o_src_ready = '0;
    w_enq       = '0;
    w_slot      = '0;
    w_n_enq     = '0;
    for (int i = 0; i < SRC; i++) begin
      o_src_ready[i] = (CW'(DEPTH) - r_count) > CW'(i);
      w_enq[i]       = i_src_valid[i] & o_src_ready[i] &
                       ~((ZERO_REG != 0) && (i_src_addr[i] == '0));
      w_slot[i]      = r_tail + w_n_enq[PW-1:0];
      if (w_enq[i]) w_n_enq = w_n_enq + CW'(1);
    end
  end

  always_comb begin
    w_n_drain = (r_count > CW'(WRITE)) ? CW'(WRITE) : r_count;
    o_we_     = '1;
    o_waddr   = '0;
    o_wdata   = '0;
    w_wptr    = '0;
    w_active  = 1'b0;
    for (int k = 0; k < WRITE; k++) begin
      w_wptr     = r_head + PW'(k);
      w_active   = CW'(k) < r_count;
      o_we_[k]   = ~w_active;
      o_waddr[k] = w_active ? r_addr[w_wptr] : '0;
      o_wdata[k] = w_active ? r_data[w_wptr] : '0;
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    o_chk_hit  = '0;
    o_chk_data = '0;
    w_fptr     = '0;
    for (int j = 0; j < CHK; j++) begin
      for (int e = 0; e < DEPTH; e++) begin
        w_fptr = r_head + PW'(e);
        if ((CW'(e) < r_count) && (r_addr[w_fptr] == i_chk_addr[j])) begin
          o_chk_hit[j]  = 1'b1;
          o_chk_data[j] = r_data[w_fptr];
        end
      end
      if ((ZERO_REG != 0) && (i_chk_addr[j] == '0)) begin
        o_chk_hit[j]  = 1'b0;
        o_chk_data[j] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_addr[e] <= '0;
        r_data[e] <= '0;
      end
    end else begin
      for (int i = 0; i < SRC; i++) begin
        if (w_enq[i]) begin
          r_addr[w_slot[i]] <= i_src_addr[i];
          r_data[w_slot[i]] <= i_src_data[i];
        end
      end
      r_head  <= r_head + w_n_drain[PW-1:0];
      r_tail  <= r_tail + w_n_enq[PW-1:0];
      r_count <= r_count + w_n_enq - w_n_drain;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
// Instance a: WRITE=1, ZERO_REG=0. Instance b: WRITE=2, ZERO_REG=1.
module tb_regfile_wb_queue;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        va = '0, vb = '0;
  logic [1:0][3:0]   addr_a = '0, addr_b = '0;
  logic [1:0][31:0]  data_a = '0, data_b = '0;
  logic [1:0][3:0]   ca_a = '0, ca_b = '0;
  logic [1:0]        rdy_a, rdy_b;
  logic [0:0][3:0]   wa_a;
  logic [0:0]        we_a;
  logic [0:0][31:0]  wd_a;
  logic [1:0][3:0]   wa_b;
  logic [1:0]        we_b;
  logic [1:0][31:0]  wd_b;
  logic [1:0]        hit_a, hit_b;
  logic [1:0][31:0]  cd_a, cd_b;

  regfile_wb_queue #(.WRITE(1), .ZERO_REG(0)) dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_src_valid(va), .o_src_ready(rdy_a), .i_src_addr(addr_a), .i_src_data(data_a),
    .o_waddr(wa_a), .o_we_(we_a), .o_wdata(wd_a),
    .i_chk_addr(ca_a), .o_chk_hit(hit_a), .o_chk_data(cd_a)
  );

  regfile_wb_queue #(.WRITE(2), .ZERO_REG(1)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_src_valid(vb), .o_src_ready(rdy_b), .i_src_addr(addr_b), .i_src_data(data_b),
    .o_waddr(wa_b), .o_we_(we_b), .o_wdata(wd_b),
    .i_chk_addr(ca_b), .o_chk_hit(hit_b), .o_chk_data(cd_b)
  );

  int  vecs = 0;
  int  miss = 0;
  int  ma_cnt = 0;
  int  mb_cnt = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Issue one cycle of stimulus to instance a; called at posedge+1, returns at next posedge+1.
  task automatic step_a(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                        input logic [3:0] a1, input logic [31:0] d1);
    logic [1:0] r;
    int acc;
    r[0] = (4 - ma_cnt) > 0;
    r[1] = (4 - ma_cnt) > 1;
    chk("ready_a", 64'(rdy_a), 64'(r));
    va = v; addr_a = {a1, a0}; data_a = {d1, d0};
    acc = 0;
    if (v[0] && r[0]) begin exp_a.push_back({a0, d0}); acc++; end
    if (v[1] && r[1]) begin exp_a.push_back({a1, d1}); acc++; end
    @(posedge clk); #1;
    ma_cnt = ma_cnt + acc - ((ma_cnt > 0) ? 1 : 0);
    va = '0;
  endtask

  task automatic step_b(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                        input logic [3:0] a1, input logic [31:0] d1);
    logic [1:0] r;
    int acc;
    r[0] = (4 - mb_cnt) > 0;
    r[1] = (4 - mb_cnt) > 1;
    chk("ready_b", 64'(rdy_b), 64'(r));
    vb = v; addr_b = {a1, a0}; data_b = {d1, d0};
    acc = 0;
    if (v[0] && r[0] && a0 != 4'd0) begin exp_b.push_back({a0, d0}); acc++; end
    if (v[1] && r[1] && a1 != 4'd0) begin exp_b.push_back({a1, d1}); acc++; end
    @(posedge clk); #1;
    mb_cnt = mb_cnt + acc - ((mb_cnt > 2) ? 2 : mb_cnt);
    vb = '0;
  endtask

  // Monitor: every active write port must match the next expected write in order.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (!we_a[0]) begin
        if (exp_a.size() == 0) begin
          vecs++; miss++;
          $display("FAIL wr_a: unexpected write addr %h data %h, none expected", wa_a[0], wd_a[0]);
        end else begin
          e = exp_a.pop_front();
          chk("wr_a_addr", 64'(wa_a[0]), 64'(e.a));
          chk("wr_a_data", 64'(wd_a[0]), 64'(e.d));
        end
      end else begin
        chk("idle_a", 64'({wa_a[0], wd_a[0]}), 64'd0);
      end
      for (int k = 0; k < 2; k++) begin
        if (!we_b[k]) begin
          if (exp_b.size() == 0) begin
            vecs++; miss++;
            $display("FAIL wr_b: unexpected write port %0d addr %h data %h", k, wa_b[k], wd_b[k]);
          end else begin
            e = exp_b.pop_front();
            chk("wr_b_addr", 64'(wa_b[k]), 64'(e.a));
            chk("wr_b_data", 64'(wd_b[k]), 64'(e.d));
          end
        end else begin
          chk("idle_b", 64'({wa_b[k], wd_b[k]}), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_we_a",  64'(we_a),  64'b1);
    chk("rst_rdy_a", 64'(rdy_a), 64'b11);
    chk("rst_hit_a", 64'(hit_a), 64'b0);
    chk("rst_cd_a",  64'(cd_a),  64'd0);
    chk("rst_we_b",  64'(we_b),  64'b11);
    chk("rst_rdy_b", 64'(rdy_b), 64'b11);
    @(posedge clk); #1;
    rst = 1'b0;

    // Build traffic, then reset mid-drain.
    step_a(2'b11, 4'd1, 32'h0000_0101, 4'd2, 32'h0000_0202);
    step_a(2'b11, 4'd3, 32'h0000_0303, 4'd4, 32'h0000_0404);
    ca_a = {4'd4, 4'd3};
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we_a",  64'(we_a),  64'b1);
    chk("mid_rst_rdy_a", 64'(rdy_a), 64'b11);
    chk("mid_rst_hit_a", 64'(hit_a), 64'b0);
    exp_a.delete();
    ma_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write pair: older src0 drains first.
    step_a(2'b11, 4'd3, 32'hAAAA_0001, 4'd5, 32'hBBBB_0002);
    chk("sw_c1_we",    64'(we_a),    64'b0);
    chk("sw_c1_waddr", 64'(wa_a[0]), 64'd3);
    step_a(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    chk("sw_c2_we",    64'(we_a),    64'b0);
    chk("sw_c2_waddr", 64'(wa_a[0]), 64'd5);
    step_a(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    chk("sw_c3_we",    64'(we_a),    64'b1);

    // Forwarding: youngest match wins; unrelated address misses.
    ca_a = {4'd6, 4'd7};
    step_a(2'b11, 4'd7, 32'h11, 4'd7, 32'h22);
    chk("fw1_hit7",  64'(hit_a[0]), 64'd1);
    chk("fw1_dat7",  64'(cd_a[0]),  64'h22);
    chk("fw1_hit6",  64'(hit_a[1]), 64'd0);
    chk("fw1_dat6",  64'(cd_a[1]),  64'd0);
    step_a(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    chk("fw2_hit7",  64'(hit_a[0]), 64'd1);
    chk("fw2_dat7",  64'(cd_a[0]),  64'h22);
    step_a(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    chk("fw3_hit7",  64'(hit_a[0]), 64'd0);
    chk("fw3_dat7",  64'(cd_a[0]),  64'd0);

    // Sustained traffic across several pointer wraps.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] a0, a1;
      a0 = 4'(2 * i);
      a1 = 4'(2 * i + 1);
      step_a((i % 7 == 6) ? 2'b10 : 2'b11, a0, 32'hC000_0000 + 32'(2 * i),
             a1, 32'hC000_0000 + 32'(2 * i + 1));
    end
    for (int i = 0; i < 6; i++) step_a(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);

    // Dual-port collision: older on port 0, younger on port 1.
    step_b(2'b11, 4'd9, 32'h1, 4'd9, 32'h2);
    chk("col_we",   64'(we_b),    64'b00);
    chk("col_p0_d", 64'(wd_b[0]), 64'h1);
    chk("col_p1_d", 64'(wd_b[1]), 64'h2);
    step_b(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);

    // Zero register: handshake completes but nothing is queued.
    ca_b = {4'd9, 4'd0};
    step_b(2'b01, 4'd0, 32'h55, 4'd0, 32'd0);
    chk("zr_we",  64'(we_b),     64'b11);
    chk("zr_hit", 64'(hit_b[0]), 64'd0);
    step_b(2'b11, 4'd0, 32'h66, 4'd9, 32'h77);
    chk("zr_mix_we",  64'(we_b),      64'b10);
    chk("zr_mix_hit", 64'(hit_b[1]),  64'd1);
    chk("zr_mix_dat", 64'(cd_b[1]),   64'h77);
    chk("zr_mix_h0",  64'(hit_b[0]),  64'd0);
    for (int i = 0; i < 3; i++) step_b(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);

    @(negedge clk); #1;
    chk("sb_a_empty", 64'(exp_a.size()), 64'd0);
    chk("sb_b_empty", 64'(exp_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
